decode_sink: RTL
================

DECODE_SINK -- requirements
Module: decode_sink

Interface
REQ-001 SHALL have parameter EXP_INIT, default 64'd1: expected data of the first beat after reset.
REQ-002 SHALL have parameter MAX_LEN, default 32: maximum beats per burst before a length error is flagged.
REQ-003 SHALL have parameter STALL_CYC, default 9: cycles s_axi_ready is held low after each accepted last beat.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port s_axi_valid, input, 1: the upstream beat is valid.
REQ-007 SHALL have port s_axi_data, input, 64: beat payload, an incrementing counter.
REQ-008 SHALL have port s_axi_last, input, 1: final beat of a burst.
REQ-009 SHALL have port s_axi_ready, output, 1: the sink accepts a beat.
REQ-010 SHALL have port err_data, output, 1: sticky flag for a payload mismatch.
REQ-011 SHALL have port err_len, output, 1: sticky flag for a burst longer than MAX_LEN.
REQ-012 SHALL have port err_cnt, output, 16: saturating count of all error events.
REQ-013 SHALL have port burst_cnt, output, 32: wrapping count of completed bursts.
REQ-014 SHALL have port burst_len, output, 8: beat count of the most recently completed burst.
REQ-015 SHALL have port burst_done, output, 1: one-cycle pulse when a last beat is accepted.

Function
REQ-016 A beat SHALL be accepted only in a cycle with s_axi_valid=1 and s_axi_ready=1; data, last and valid in any other cycle SHALL be ignored.
REQ-017 The state machine SHALL have three states: RECV (ready=1), STALL (ready=0, stall counter runs) and ERRHOLD.
REQ-018 Reset SHALL enter RECV; an accepted last beat SHALL move RECV to STALL, and STALL SHALL return to RECV after exactly STALL_CYC cycles.
REQ-019 The expected-data register SHALL start at EXP_INIT, increment by 1 (mod 2^64) on every accepted beat, and continue across burst boundaries.
REQ-020 An accepted beat whose data differs from the expected value SHALL set err_data the next cycle and increment err_cnt.
REQ-021 After a mismatch, the expected value SHALL resynchronise to the received data + 1.
REQ-022 The beat counter SHALL count accepted beats within the current burst.
REQ-023 On an accepted last beat, burst_len SHALL take the beat count including that beat, burst_cnt SHALL increment (wrapping at 2^32), burst_done SHALL pulse one cycle, and the beat counter SHALL clear.
REQ-024 When the beat counter reaches MAX_LEN and the next accepted beat is not last, err_len SHALL set and err_cnt SHALL increment once.
REQ-025 After a length error, the FSM SHALL enter ERRHOLD, where ready stays 1 and beats are discarded (not checked or counted) until a last beat is accepted, then go to STALL.
REQ-026 A data error and a length error on the same beat SHALL increment err_cnt by 2.
REQ-027 err_cnt SHALL saturate at 16'hFFFF; err_data and err_len SHALL clear only on reset.
REQ-028 burst_len SHALL saturate at 255 if a burst exceeds 255 beats.

Reset
REQ-029 Asserting reset SHALL immediately force s_axi_ready=0, err_data=0, err_len=0, err_cnt=0, burst_cnt=0, burst_len=0 and burst_done=0, with the FSM in RECV and expected data = EXP_INIT.
REQ-030 s_axi_ready SHALL rise on the first clock edge after reset deasserts; reset mid-burst SHALL discard the partial burst without flagging an error.

Configuration
REQ-031 With DECODE_SINK_BP_EN defined, a 16-bit LFSR (seed 16'hACE1, advancing every cycle) SHALL gate ready in RECV/ERRHOLD: ready = LFSR[0] | LFSR[3].
REQ-032 Without DECODE_SINK_BP_EN, ready SHALL be 1 in every cycle of RECV and ERRHOLD, and the LFSR SHALL not exist.

Verification
REQ-033 A 7-beat burst with data 1..7 and last on beat 7 SHALL give burst_len=7, burst_cnt=1, err_cnt=0, one burst_done pulse, then ready low for 9 cycles.
REQ-034 Two bursts 1..7 then 8..33 (26 beats) SHALL give burst_len=26, burst_cnt=2, err_data=0.
REQ-035 A burst 1,2,5,6 SHALL set err_data after beat 5, err_cnt=1, and flag no error on beat 6.
REQ-036 A 40 beats burst with last only on beat 40 (MAX_LEN=32) SHALL set err_len on beat 33, discard beats 33..40, and leave burst_cnt unchanged.
REQ-037 Reset asserted at beat 3 of a burst SHALL give all outputs 0 immediately; a new burst starting at data 1 SHALL then check clean.
REQ-038 With DECODE_SINK_BP_EN defined and valid held high, 200 beats SHALL be accepted with err_cnt=0 and ready low in at least one RECV cycle.

Source files
------------

// File: rtl/decode_sink.sv
// ============================================================================
// decode_sink
//
// Purpose:
//   Streaming sink for bursts whose payload is an incrementing 64-bit counter.
//   Every accepted beat is checked against an expected-value register. The
//   sink tracks burst length and completed-burst statistics. After each
//   completed burst, it deasserts ready for a fixed number of cycles.
//
// Parameters:
//   EXP_INIT  - expected payload of the first beat after reset
//   MAX_LEN   - beats per burst before a non-last beat is a length error
//   STALL_CYC - cycles s_axi_ready is held low after each accepted last beat
//
// Ports:
//   clk         in   1   single clock, rising edge
//   reset       in   1   asynchronous, active-high reset
//   s_axi_valid in   1   upstream beat valid
//   s_axi_data  in  64   beat payload (incrementing counter)
//   s_axi_last  in   1   final beat of a burst
//   s_axi_ready out  1   sink accepts a beat this cycle
//   err_data    out  1   sticky payload-mismatch flag
//   err_len     out  1   sticky over-length-burst flag
//   err_cnt     out 16   saturating count of all error events
//   burst_cnt   out 32   wrapping count of completed bursts
//   burst_len   out  8   beat count of last completed burst (saturates at 255)
//   burst_done  out  1   one-cycle pulse when a last beat completes a burst
//
// Configuration:
//   DECODE_SINK_BP_EN - when defined, a 16-bit LFSR (seed 16'hACE1) advancing
//                       every cycle throttles ready in RECV/ERRHOLD with
//                       ready = LFSR[0] | LFSR[3]. When undefined, ready is
//                       always 1 in those states and no LFSR is built.
// ============================================================================
module decode_sink #(
    parameter logic [63:0] EXP_INIT  = 64'd1,
    parameter int          MAX_LEN   = 32,
    parameter int          STALL_CYC = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axi_valid,
    input  logic [63:0] s_axi_data,
    input  logic        s_axi_last,
    output logic        s_axi_ready,
    output logic        err_data,
    output logic        err_len,
    output logic [15:0] err_cnt,
    output logic [31:0] burst_cnt,
    output logic [7:0]  burst_len,
    output logic        burst_done
);

    typedef enum logic [1:0] {
        ST_RECV    = 2'd0,
        ST_STALL   = 2'd1,
        ST_ERRHOLD = 2'd2
    } state_t;

    // The beat counter never exceeds MAX_LEN while a burst is live. The
    // width still leaves room for MAX_LEN+1, the length including the
    // current beat.
    localparam int BEAT_W  = $clog2(MAX_LEN + 2);
    localparam int STALL_W = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;

    localparam logic [BEAT_W-1:0]  MAX_BEATS  = BEAT_W'(MAX_LEN);
    localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_CYC - 1);

    state_t             state_q;
    logic               ready_q;
    logic [STALL_W-1:0] stall_cnt_q;
    logic [BEAT_W-1:0]  beat_cnt_q;
    logic [63:0]        exp_q;
    logic               err_data_q;
    logic               err_len_q;
    logic [15:0]        err_cnt_q;
    logic [31:0]        burst_cnt_q;
    logic [7:0]         burst_len_q;
    logic               burst_done_q;

    logic               accept;
    logic               check_beat;
    logic               data_bad;
    logic               len_bad;
    logic [1:0]         err_inc;
    logic [16:0]        err_sum;
    logic [15:0]        err_cnt_d;
    logic [63:0]        exp_d;
    logic [31:0]        beat_inc;
    logic [7:0]         burst_len_d;
    logic               bp_gate;

`ifdef DECODE_SINK_BP_EN
    // Fibonacci LFSR with taps 16,14,13,11 (maximal length). It free-runs
    // from reset. ready_q is loaded from the next LFSR value, so the visible
    // ready always matches the LFSR bits currently held.
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign bp_gate = lfsr_d[0] | lfsr_d[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign bp_gate = 1'b1;
`endif

    // NOTE: every signal written in always_comb gets a default value first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        accept     = s_axi_valid & ready_q;
        check_beat = accept && (state_q == ST_RECV);
        data_bad   = check_beat && (s_axi_data != exp_q);
        len_bad    = check_beat && (beat_cnt_q == MAX_BEATS) && !s_axi_last;

        // Zero, one, or two error events this beat. The sum is clamped
        // instead of allowed to wrap.
        err_inc   = {1'b0, data_bad} + {1'b0, len_bad};
        err_sum   = {1'b0, err_cnt_q} + {15'd0, err_inc};
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

        // A checked beat resynchronises to data+1; on a match, this equals
        // exp+1. Discarded beats in ERRHOLD still advance the expected value
        // by one.
        exp_d = (state_q == ST_RECV) ? (s_axi_data + 64'd1) : (exp_q + 64'd1);

        beat_inc    = 32'(beat_cnt_q) + 32'd1;
        burst_len_d = (beat_inc > 32'd255) ? 8'hFF : beat_inc[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge, independent of
    // statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RECV;
            ready_q      <= 1'b0;
            stall_cnt_q  <= '0;
            beat_cnt_q   <= '0;
            exp_q        <= EXP_INIT;
            err_data_q   <= 1'b0;
            err_len_q    <= 1'b0;
            err_cnt_q    <= 16'd0;
            burst_cnt_q  <= 32'd0;
            burst_len_q  <= 8'd0;
            burst_done_q <= 1'b0;
        end else begin
            burst_done_q <= 1'b0;
            err_cnt_q    <= err_cnt_d;

            if (accept) begin
                exp_q <= exp_d;
            end
            if (data_bad) begin
                err_data_q <= 1'b1;
            end
            if (len_bad) begin
                err_len_q <= 1'b1;
            end

            case (state_q)
                ST_RECV: begin
                    ready_q <= bp_gate;
                    if (accept) begin
                        if (len_bad) begin
                            // The over-length beat is dropped from the burst,
                            // and the rest of the burst is discarded.
                            state_q    <= ST_ERRHOLD;
                            beat_cnt_q <= '0;
                        end else if (s_axi_last) begin
                            state_q      <= ST_STALL;
                            ready_q      <= 1'b0;
                            stall_cnt_q  <= STALL_LOAD;
                            beat_cnt_q   <= '0;
                            burst_len_q  <= burst_len_d;
                            burst_cnt_q  <= burst_cnt_q + 32'd1;
                            burst_done_q <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                        end
                    end
                end

                ST_ERRHOLD: begin
                    ready_q <= bp_gate;
                    if (accept && s_axi_last) begin
                        state_q     <= ST_STALL;
                        ready_q     <= 1'b0;
                        stall_cnt_q <= STALL_LOAD;
                    end
                end

                ST_STALL: begin
                    // The counter is loaded with STALL_CYC-1 on entry. The
                    // state is therefore held for STALL_CYC full cycles, and
                    // ready rises on the exit edge.
                    if (stall_cnt_q == '0) begin
                        state_q <= ST_RECV;
                        ready_q <= bp_gate;
                    end else begin
                        stall_cnt_q <= stall_cnt_q - STALL_W'(1);
                        ready_q     <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_RECV;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi_ready = ready_q;
    assign err_data    = err_data_q;
    assign err_len     = err_len_q;
    assign err_cnt     = err_cnt_q;
    assign burst_cnt   = burst_cnt_q;
    assign burst_len   = burst_len_q;
    assign burst_done  = burst_done_q;

endmodule
